// File: rtl/nv_nvdla_cacc_reg_seq.sv
// CACC register-programming sequencer: writes one layer configuration, kicks op_en, polls until
// the layer completes and returns OUT_SATURATION. Optional readback checking: NV_NVDLA_CACC_REG_SEQ_VERIFY_EN.
module nv_nvdla_cacc_reg_seq #(
    parameter int POLL_INTERVAL  = 16,
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int TMR_W          = 17
) (
    input  logic        nvdla_core_clk,
    input  logic        nvdla_core_rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [4:0]  cmd_batches,
    input  logic [4:0]  cmd_clip_truncate,
    input  logic [31:0] cmd_dataout_addr,
    input  logic        cmd_line_packed,
    input  logic        cmd_surf_packed,
    input  logic [12:0] cmd_dataout_width,
    input  logic [12:0] cmd_dataout_height,
    input  logic [12:0] cmd_dataout_channel,
    input  logic [23:0] cmd_line_stride,
    input  logic [23:0] cmd_surf_stride,
    input  logic        cmd_conv_mode,
    input  logic [1:0]  cmd_proc_precision,
    output logic [11:0] reg_offset,
    output logic [31:0] reg_wr_data,
    output logic        reg_wr_en,
    input  logic [31:0] reg_rd_data,
    output logic        done_valid,
    input  logic        done_ready,
    output logic [31:0] done_sat_count,
    output logic        done_timeout,
    output logic        busy
);
    typedef enum logic [2:0] {
        ST_IDLE, ST_WRITE, ST_VRFY, ST_KICK, ST_WAIT, ST_POLL, ST_SAT, ST_DONE
    } state_t;

    typedef struct packed {
        logic [4:0]  batches;
        logic [4:0]  clip;
        logic [31:0] addr;
        logic        line_packed;
        logic        surf_packed;
        logic [12:0] width;
        logic [12:0] height;
        logic [12:0] channel;
        logic [23:0] line_stride;
        logic [23:0] surf_stride;
        logic        conv_mode;
        logic [1:0]  prec;
    } cfg_t;

    localparam logic [TMR_W-1:0] POLL_LAST = TMR_W'(POLL_INTERVAL - 1);
    localparam logic [TMR_W-1:0] TMO_LAST  = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LAST_IDX  = 4'd8;

    function automatic logic [11:0] wr_offset(input logic [3:0] idx);
        logic [11:0] off;
        case (idx)
            4'd0:    off = 12'h00c;
            4'd1:    off = 12'h010;
            4'd2:    off = 12'h014;
            4'd3:    off = 12'h018;
            4'd4:    off = 12'h01c;
            4'd5:    off = 12'h020;
            4'd6:    off = 12'h024;
            4'd7:    off = 12'h028;
            4'd8:    off = 12'h02c;
            default: off = 12'h000;
        endcase
        return off;
    endfunction

    function automatic logic [31:0] wr_value(input logic [3:0] idx, input cfg_t c);
        logic [31:0] val;
        case (idx)
            4'd0:    val = {18'b0, c.prec, 11'b0, c.conv_mode};
            4'd1:    val = {3'b0, c.height, 3'b0, c.width};
            4'd2:    val = {19'b0, c.channel};
            4'd3:    val = c.addr;
            4'd4:    val = {27'b0, c.batches};
            4'd5:    val = {8'b0, c.line_stride};
            4'd6:    val = {8'b0, c.surf_stride};
            4'd7:    val = {15'b0, c.surf_packed, 15'b0, c.line_packed};
            4'd8:    val = {27'b0, c.clip};
            default: val = 32'h0000_0000;
        endcase
        return val;
    endfunction

`ifdef NV_NVDLA_CACC_REG_SEQ_VERIFY_EN
    function automatic logic [31:0] impl_mask(input logic [3:0] idx);
        logic [31:0] m;
        case (idx)
            4'd0:    m = 32'h0000_3001;
            4'd1:    m = 32'h1fff_1fff;
            4'd2:    m = 32'h0000_1fff;
            4'd3:    m = 32'hffff_ffff;
            4'd4:    m = 32'h0000_001f;
            4'd5:    m = 32'h00ff_ffff;
            4'd6:    m = 32'h00ff_ffff;
            4'd7:    m = 32'h0001_0001;
            4'd8:    m = 32'h0000_001f;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction
`endif

    state_t           state_r, state_s;
    logic [3:0]       idx_r, idx_s;
    logic [TMR_W-1:0] poll_cnt_r, poll_cnt_s;
    logic [TMR_W-1:0] tmo_cnt_r, tmo_cnt_s;
    logic             armed_r, armed_s;
    cfg_t             cfg_r, cfg_s, cmd_cfg_s;
    logic [11:0]      offset_s;
    logic [31:0]      wdata_s, sat_s;
    logic             wen_s, tmo_flag_s;

    // Gather the command ports into one configuration record
    always_comb begin
        cmd_cfg_s.batches     = cmd_batches;
        cmd_cfg_s.clip        = cmd_clip_truncate;
        cmd_cfg_s.addr        = cmd_dataout_addr;
        cmd_cfg_s.line_packed = cmd_line_packed;
        cmd_cfg_s.surf_packed = cmd_surf_packed;
        cmd_cfg_s.width       = cmd_dataout_width;
        cmd_cfg_s.height      = cmd_dataout_height;
        cmd_cfg_s.channel     = cmd_dataout_channel;
        cmd_cfg_s.line_stride = cmd_line_stride;
        cmd_cfg_s.surf_stride = cmd_surf_stride;
        cmd_cfg_s.conv_mode   = cmd_conv_mode;
        cmd_cfg_s.prec        = cmd_proc_precision;
    end

    // Next-state logic; bus outputs are derived from the next state so they register in step with it
    always_comb begin
        state_s    = state_r;
        idx_s      = idx_r;
        poll_cnt_s = poll_cnt_r;
        tmo_cnt_s  = tmo_cnt_r;
        armed_s    = armed_r;
        cfg_s      = cfg_r;
        sat_s      = done_sat_count;
        tmo_flag_s = done_timeout;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    state_s = ST_WRITE;
                    idx_s   = 4'd0;
                    cfg_s   = cmd_cfg_s;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
`ifdef NV_NVDLA_CACC_REG_SEQ_VERIFY_EN
                state_s = ST_VRFY;
`else
                if (idx_r == LAST_IDX) begin
                    state_s = ST_KICK;
                end else begin
                    idx_s = idx_r + 4'd1;
                end
`endif
            end
            ST_VRFY: begin
`ifdef NV_NVDLA_CACC_REG_SEQ_VERIFY_EN
                if ((reg_rd_data & impl_mask(idx_r)) != (wr_value(idx_r, cfg_r) & impl_mask(idx_r))) begin
                    state_s    = ST_DONE;
                    tmo_flag_s = 1'b1;
                    sat_s      = {20'b0, wr_offset(idx_r)};
                end else if (idx_r == LAST_IDX) begin
                    state_s = ST_KICK;
                end else begin
                    state_s = ST_WRITE;
                    idx_s   = idx_r + 4'd1;
                end
`else
                state_s = ST_IDLE;
`endif
            end
            ST_KICK: begin
                state_s    = ST_WAIT;
                poll_cnt_s = '0;
                tmo_cnt_s  = '0;
                armed_s    = 1'b0;
            end
            ST_WAIT: begin
                if (tmo_cnt_r == TMO_LAST) begin
                    state_s    = ST_DONE;
                    tmo_flag_s = 1'b1;
                    sat_s      = 32'h0000_0000;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMR_W'(1);
                    if (poll_cnt_r == POLL_LAST) begin
                        state_s    = ST_POLL;
                        poll_cnt_s = '0;
                    end else begin
                        poll_cnt_s = poll_cnt_r + TMR_W'(1);
                    end
                end
            end
            ST_POLL: begin
                // Timeout wins over whatever op_en reads back in the same cycle
                if (tmo_cnt_r == TMO_LAST) begin
                    state_s    = ST_DONE;
                    tmo_flag_s = 1'b1;
                    sat_s      = 32'h0000_0000;
                end else begin
                    tmo_cnt_s = tmo_cnt_r + TMR_W'(1);
                    if (reg_rd_data[0]) begin
                        armed_s = 1'b1;
                        state_s = ST_WAIT;
                    end else if (armed_r) begin
                        state_s = ST_SAT;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
            end
            ST_SAT: begin
                state_s    = ST_DONE;
                sat_s      = reg_rd_data;
                tmo_flag_s = 1'b0;
            end
            ST_DONE: begin
                if (done_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end
            default: state_s = ST_IDLE;
        endcase

        offset_s = 12'h000;
        wdata_s  = 32'h0000_0000;
        wen_s    = 1'b0;
        case (state_s)
            ST_WRITE: begin
                wen_s    = 1'b1;
                offset_s = wr_offset(idx_s);
                wdata_s  = wr_value(idx_s, cfg_s);
            end
            ST_VRFY: offset_s = wr_offset(idx_s);
            ST_KICK: begin
                wen_s    = 1'b1;
                offset_s = 12'h008;
                wdata_s  = 32'h0000_0001;
            end
            ST_POLL: offset_s = 12'h008;
            ST_SAT:  offset_s = 12'h030;
            default: offset_s = 12'h000;
        endcase
    end

    // State, counters, captured configuration and registered outputs
    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rst) begin
            state_r        <= ST_IDLE;
            idx_r          <= 4'd0;
            poll_cnt_r     <= '0;
            tmo_cnt_r      <= '0;
            armed_r        <= 1'b0;
            cfg_r          <= '0;
            reg_offset     <= 12'h000;
            reg_wr_data    <= 32'h0000_0000;
            reg_wr_en      <= 1'b0;
            done_valid     <= 1'b0;
            done_sat_count <= 32'h0000_0000;
            done_timeout   <= 1'b0;
        end else begin
            state_r        <= state_s;
            idx_r          <= idx_s;
            poll_cnt_r     <= poll_cnt_s;
            tmo_cnt_r      <= tmo_cnt_s;
            armed_r        <= armed_s;
            cfg_r          <= cfg_s;
            reg_offset     <= offset_s;
            reg_wr_data    <= wdata_s;
            reg_wr_en      <= wen_s;
            done_valid     <= (state_s == ST_DONE);
            done_sat_count <= sat_s;
            done_timeout   <= tmo_flag_s;
        end
    end

    assign cmd_ready = (state_r == ST_IDLE);
    assign busy      = (state_r != ST_IDLE);
endmodule

// File: tb/tb_nv_nvdla_cacc_reg_seq.sv
// Randomized bench for nv_nvdla_cacc_reg_seq against a behavioural CACC register group and
// a cycle-level completion predictor.
module tb_nv_nvdla_cacc_reg_seq;
    localparam int PI   = 4;
    localparam int TMO  = 64;
`ifdef NV_NVDLA_CACC_REG_SEQ_VERIFY_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif

    typedef struct packed {
        logic [4:0]  batches;
        logic [4:0]  clip;
        logic [31:0] addr;
        logic        line_packed;
        logic        surf_packed;
        logic [12:0] width;
        logic [12:0] height;
        logic [12:0] channel;
        logic [23:0] line_stride;
        logic [23:0] surf_stride;
        logic        conv_mode;
        logic [1:0]  prec;
    } cfg_t;

    logic        nvdla_core_clk = 1'b0;
    logic        nvdla_core_rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    cfg_t        cmd = '0;
    logic [11:0] reg_offset;
    logic [31:0] reg_wr_data;
    logic        reg_wr_en;
    logic [31:0] reg_rd_data;
    logic        done_valid;
    logic        done_ready = 1'b0;
    logic [31:0] done_sat_count;
    logic        done_timeout;
    logic        busy;

    int          n_cmp = 0;
    int          n_mis = 0;
    int          cyc = 0;
    int          on_start = 32'h7fff_0000;
    int          on_end = 32'h7fff_0000;
    logic [31:0] sat_val = 32'h0;
    logic        addr_fault = 1'b0;
    logic [31:0] regs [0:15];
    logic        op_en;

    nv_nvdla_cacc_reg_seq #(.POLL_INTERVAL(PI), .TIMEOUT_CYCLES(TMO), .TMR_W(8)) dut (
        .nvdla_core_clk(nvdla_core_clk), .nvdla_core_rst(nvdla_core_rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_batches(cmd.batches), .cmd_clip_truncate(cmd.clip), .cmd_dataout_addr(cmd.addr),
        .cmd_line_packed(cmd.line_packed), .cmd_surf_packed(cmd.surf_packed),
        .cmd_dataout_width(cmd.width), .cmd_dataout_height(cmd.height),
        .cmd_dataout_channel(cmd.channel), .cmd_line_stride(cmd.line_stride),
        .cmd_surf_stride(cmd.surf_stride), .cmd_conv_mode(cmd.conv_mode),
        .cmd_proc_precision(cmd.prec),
        .reg_offset(reg_offset), .reg_wr_data(reg_wr_data), .reg_wr_en(reg_wr_en),
        .reg_rd_data(reg_rd_data),
        .done_valid(done_valid), .done_ready(done_ready), .done_sat_count(done_sat_count),
        .done_timeout(done_timeout), .busy(busy)
    );

    always #5 nvdla_core_clk = ~nvdla_core_clk;

    // Cycle index: value seen during a cycle, advanced at its closing edge
    always @(posedge nvdla_core_clk) cyc <= cyc + 1;

    // Register group model; addr_fault makes DATAOUT_ADDR read back as zero
    always @(posedge nvdla_core_clk)
        if (reg_wr_en)
            regs[reg_offset[5:2]] <= (addr_fault && reg_offset == 12'h018) ? 32'h0 : reg_wr_data;

    assign op_en = (cyc >= on_start) && (cyc < on_end);

    always_comb begin
        case (reg_offset)
            12'h008: reg_rd_data = {31'b0, op_en};
            12'h030: reg_rd_data = sat_val;
            default: reg_rd_data = regs[reg_offset[5:2]];
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.batches = 5'($urandom);         c.clip = 5'($urandom);
        c.addr = $urandom | 32'h100;      c.line_packed = 1'($urandom);
        c.surf_packed = 1'($urandom);     c.width = 13'($urandom);
        c.height = 13'($urandom);         c.channel = 13'($urandom);
        c.line_stride = 24'($urandom);    c.surf_stride = 24'($urandom);
        c.conv_mode = 1'($urandom);       c.prec = 2'($urandom);
        return c;
    endfunction

    // Completion predictor: polls land every PI+1 cycles after the kick
    task automatic predict(input int k, input int rise, input int dur, output int dcyc, output bit tmo);
        bit armed = 1'b0;
        tmo  = 1'b1;
        dcyc = k + TMO + 1;
        for (int j = 1; j < 10000; j++) begin
            int p = k + (PI + 1) * j;
            if (p - k >= TMO) return;
            if (p >= k + rise && p < k + rise + dur) armed = 1'b1;
            else if (armed) begin
                tmo  = 1'b0;
                dcyc = p + 2;
                return;
            end
        end
    endtask

    task automatic send_cmd(input cfg_t c);
        @(negedge nvdla_core_clk);
        check("cmd_ready_idle", {31'b0, cmd_ready}, 32'd1);
        cmd = c;
        cmd_valid = 1'b1;
        @(negedge nvdla_core_clk);
        cmd_valid = 1'b0;
    endtask

    task automatic run_txn(input cfg_t c, input int rise, input int dur, input logic [31:0] sat, input int hold);
        logic [31:0] dat [0:8];
        int kick, dcyc, t0, kicks;
        bit tmo, saw_sat, got_done;
        logic [31:0] sat_hold;
        dat[0] = {18'b0, c.prec, 11'b0, c.conv_mode};
        dat[1] = {3'b0, c.height, 3'b0, c.width};
        dat[2] = {19'b0, c.channel};
        dat[3] = c.addr;
        dat[4] = {27'b0, c.batches};
        dat[5] = {8'b0, c.line_stride};
        dat[6] = {8'b0, c.surf_stride};
        dat[7] = {15'b0, c.surf_packed, 15'b0, c.line_packed};
        dat[8] = {27'b0, c.clip};
        sat_val = sat;
        send_cmd(c);
        for (int i = 0; i < 9; i++) begin
            check("wr_en", {31'b0, reg_wr_en}, 32'd1);
            check("wr_off", {20'b0, reg_offset}, 32'h00c + 32'(4 * i));
            check("wr_data", reg_wr_data, dat[i]);
            @(negedge nvdla_core_clk);
            if (STEP == 2) begin
                check("rb_en", {31'b0, reg_wr_en}, 32'd0);
                check("rb_off", {20'b0, reg_offset}, 32'h00c + 32'(4 * i));
                @(negedge nvdla_core_clk);
            end
        end
        check("kick_en", {31'b0, reg_wr_en}, 32'd1);
        check("kick_off", {20'b0, reg_offset}, 32'h008);
        check("kick_data", reg_wr_data, 32'd1);
        kick = cyc;
        on_start = kick + rise;
        on_end = kick + rise + dur;
        predict(kick, rise, dur, dcyc, tmo);
        saw_sat = 1'b0;
        got_done = 1'b0;
        kicks = 0;
        for (t0 = 0; t0 < 300; t0++) begin
            @(negedge nvdla_core_clk);
            if (reg_wr_en) kicks++;
            if (reg_offset == 12'h030) saw_sat = 1'b1;
            if (cyc == kick + PI + 1) begin
                check("first_poll_off", {20'b0, reg_offset}, 32'h008);
                check("first_poll_en", {31'b0, reg_wr_en}, 32'd0);
            end
            if (done_valid) begin
                got_done = 1'b1;
                break;
            end
        end
        on_start = 32'h7fff_0000;
        on_end = 32'h7fff_0000;
        check("done_seen", {31'b0, got_done}, 32'd1);
        check("done_cycle", 32'(cyc), 32'(dcyc));
        check("done_timeout", {31'b0, done_timeout}, {31'b0, tmo});
        check("done_sat", done_sat_count, tmo ? 32'h0 : sat);
        check("sat_read", {31'b0, saw_sat}, {31'b0, ~tmo});
        check("writes_after_kick", 32'(kicks), 32'd0);
        sat_hold = done_sat_count;
        cmd_valid = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge nvdla_core_clk);
            check("hold_valid", {31'b0, done_valid}, 32'd1);
            check("hold_cmd_ready", {31'b0, cmd_ready}, 32'd0);
            check("hold_sat", done_sat_count, sat_hold);
        end
        cmd_valid = 1'b0;
        done_ready = 1'b1;
        @(negedge nvdla_core_clk);
        done_ready = 1'b0;
        check("release_valid", {31'b0, done_valid}, 32'd0);
        check("release_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("release_busy", {31'b0, busy}, 32'd0);
    endtask

    task automatic run_reset_abort();
        int writes = 0;
        send_cmd(rand_cfg());
        repeat (3 * STEP) @(negedge nvdla_core_clk);
        check("abort_at_addr", {20'b0, reg_offset}, 32'h018);
        nvdla_core_rst = 1'b1;
        @(negedge nvdla_core_clk);
        nvdla_core_rst = 1'b0;
        check("abort_wr_en", {31'b0, reg_wr_en}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_cmd_ready", {31'b0, cmd_ready}, 32'd1);
        check("abort_offset", {20'b0, reg_offset}, 32'h0);
        repeat (30) begin
            @(negedge nvdla_core_clk);
            if (reg_wr_en) writes++;
        end
        check("abort_no_writes", 32'(writes), 32'd0);
    endtask

`ifdef NV_NVDLA_CACC_REG_SEQ_VERIFY_EN
    task automatic run_verify_fault();
        int kicks = 0;
        bit got_done = 1'b0;
        addr_fault = 1'b1;
        send_cmd(rand_cfg());
        for (int t = 0; t < 60; t++) begin
            if (reg_wr_en && reg_offset == 12'h008) kicks++;
            if (done_valid) begin
                got_done = 1'b1;
                break;
            end
            @(negedge nvdla_core_clk);
        end
        check("vfy_done_seen", {31'b0, got_done}, 32'd1);
        check("vfy_timeout", {31'b0, done_timeout}, 32'd1);
        check("vfy_sat_offset", done_sat_count, 32'h018);
        check("vfy_no_kick", 32'(kicks), 32'd0);
        done_ready = 1'b1;
        @(negedge nvdla_core_clk);
        done_ready = 1'b0;
        addr_fault = 1'b0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        cfg_t c;
        repeat (3) @(negedge nvdla_core_clk);
        check("rst_wr_en", {31'b0, reg_wr_en}, 32'd0);
        check("rst_offset", {20'b0, reg_offset}, 32'h0);
        check("rst_wr_data", reg_wr_data, 32'h0);
        check("rst_done_valid", {31'b0, done_valid}, 32'd0);
        check("rst_sat", done_sat_count, 32'h0);
        check("rst_timeout", {31'b0, done_timeout}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        nvdla_core_rst = 1'b0;

        c = '0;
        c.width = 13'h20;
        c.height = 13'h10;
        c.prec = 2'd2;
        run_txn(c, 3, 40, 32'h0000_1234, 5);
        for (int n = 0; n < 6; n++)
            run_txn(rand_cfg(), $urandom_range(1, 3), $urandom_range(PI + 1, 40), $urandom, $urandom_range(0, 3));
        run_txn(rand_cfg(), 100000, 10, 32'hdead_beef, 2);
        run_reset_abort();
        run_txn(rand_cfg(), 2, 12, $urandom, 1);
`ifdef NV_NVDLA_CACC_REG_SEQ_VERIFY_EN
        run_verify_fault();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
